// File: rtl/key_filter_multi.sv
// key_filter_multi: per-channel 2-flop synchroniser, debounce counter, debounced level and edge pulses.
// Optional auto-repeat while a key is held is built only when KEY_FILTER_REPEAT_EN is defined.
module key_filter_multi #(
  parameter int                KEY_NUM    = 4,
  parameter int                CNT_W      = 22,
  parameter logic [CNT_W-1:0]  CNT_MAX    = 22'd999_999,
  parameter int                ACTIVE_LOW = 1,
  parameter int                HOLD_W     = 26,
  parameter logic [HOLD_W-1:0] REPEAT_DLY = 26'd49_999_999,
  parameter logic [HOLD_W-1:0] REPEAT_PER = 26'd9_999_999
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_repeat
);

  // Raw level of a released key; also the value XORed in to make pressed = 1.
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    logic             sync_q1;
    logic             sync_q2;
    logic             synced;
    logic             state_q;
    logic             press_q;
    logic             release_q;
    logic             settle;
    logic [CNT_W-1:0] cnt_q;

    assign synced = sync_q2 ^ IDLE_LVL;
    assign settle = (synced != state_q) && (cnt_q == CNT_MAX);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        sync_q1   <= IDLE_LVL;
        sync_q2   <= IDLE_LVL;
        cnt_q     <= '0;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync_q1   <= key_in[i];
        sync_q2   <= sync_q1;
        press_q   <= settle & synced;
        release_q <= settle & ~synced;
        // Equality compare against CNT_MAX keeps the counter from ever wrapping.
        if ((synced == state_q) || settle) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        if (settle) begin
          state_q <= synced;
        end
      end
    end

    assign key_state[i]   = state_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;

`ifdef KEY_FILTER_REPEAT_EN
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_nxt;
    logic              repeat_q;

    // Reloading to DLY-PER+1 makes the counter return to DLY every PER cycles.
    assign hold_nxt = (hold_q == REPEAT_DLY) ? (REPEAT_DLY - REPEAT_PER + 1'b1)
                                             : (hold_q + 1'b1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        hold_q   <= '0;
        repeat_q <= 1'b0;
      end else if (state_q && !settle) begin
        hold_q   <= hold_nxt;
        repeat_q <= (hold_nxt == REPEAT_DLY);
      end else begin
        hold_q   <= '0;
        repeat_q <= 1'b0;
      end
    end

    assign key_repeat[i] = repeat_q;
`else
    assign key_repeat[i] = 1'b0;
`endif
  end

`ifndef KEY_FILTER_REPEAT_EN
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DLY, REPEAT_PER};
`endif

endmodule

// File: tb/tb_key_filter_multi.sv
// Self-checking bench for key_filter_multi with CNT_MAX=9 (press/release visible on the 12th edge).
module tb_key_filter_multi;
  localparam int N = 4;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n;
  logic [N-1:0] key_in;
  logic [N-1:0] key_state;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] key_repeat;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int press_cnt[N];
  int rel_cnt[N];
  int first_press[N];
`ifdef KEY_FILTER_REPEAT_EN
  int rep_cnt = 0;
  int rep_at[$];
`endif

  typedef struct {
    logic [N-1:0] k;
    int           w;
    logic [N-1:0] st;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
  } vec_t;

  typedef struct {
    int           due;
    int           id;
    logic [N-1:0] st;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
  } exp_t;

  vec_t vt[16];
  exp_t sb[$];

  always #5 sys_clk = ~sys_clk;

  key_filter_multi #(
    .KEY_NUM    (N),
    .CNT_W      (22),
    .CNT_MAX    (22'd9),
    .ACTIVE_LOW (1),
    .HOLD_W     (26),
    .REPEAT_DLY (26'd20),
    .REPEAT_PER (26'd5)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat)
  );

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void clr_counts();
    for (int c = 0; c < N; c++) begin
      press_cnt[c]   = 0;
      rel_cnt[c]     = 0;
      first_press[c] = -1;
    end
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge sys_clk);
    #1;
    cyc++;
    chk("press_release_exclusive", int'(key_press & key_release), 0);
`ifndef KEY_FILTER_REPEAT_EN
    chk("repeat_tied_low", int'(key_repeat), 0);
`else
    if (key_repeat[2]) begin
      rep_cnt++;
      rep_at.push_back(cyc);
    end
`endif
    for (int c = 0; c < N; c++) begin
      if (key_press[c]) begin
        press_cnt[c]++;
        if (first_press[c] < 0) first_press[c] = cyc;
      end
      if (key_release[c]) rel_cnt[c]++;
    end
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk($sformatf("v%0d_state", e.id), int'(key_state), int'(e.st));
      chk($sformatf("v%0d_press", e.id), int'(key_press), int'(e.pr));
      chk($sformatf("v%0d_release", e.id), int'(key_release), int'(e.rl));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int edge_k;

    // raw key_in: 0 = pressed. Each row waits w edges after driving k.
    vt[0]  = '{4'b1110, 11, 4'b0000, 4'b0000, 4'b0000};
    vt[1]  = '{4'b1110,  1, 4'b0001, 4'b0001, 4'b0000};
    vt[2]  = '{4'b1110,  1, 4'b0001, 4'b0000, 4'b0000};
    vt[3]  = '{4'b1110, 10, 4'b0001, 4'b0000, 4'b0000};
    vt[4]  = '{4'b1111, 11, 4'b0001, 4'b0000, 4'b0000};
    vt[5]  = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0001};
    vt[6]  = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0000};
    vt[7]  = '{4'b0000, 11, 4'b0000, 4'b0000, 4'b0000};
    vt[8]  = '{4'b0000,  1, 4'b1111, 4'b1111, 4'b0000};
    vt[9]  = '{4'b0000,  1, 4'b1111, 4'b0000, 4'b0000};
    vt[10] = '{4'b1111, 12, 4'b0000, 4'b0000, 4'b1111};
    vt[11] = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0000};
    vt[12] = '{4'b1010, 12, 4'b0101, 4'b0101, 4'b0000};
    vt[13] = '{4'b0011, 12, 4'b1100, 4'b1000, 4'b0001};
    vt[14] = '{4'b0011,  1, 4'b1100, 4'b0000, 4'b0000};
    vt[15] = '{4'b1111, 12, 4'b0000, 4'b0000, 4'b1100};

    clr_counts();
    key_in    = 4'hF;
    sys_rst_n = 1'b1;
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_state", int'(key_state), 0);
    chk("rst_press", int'(key_press), 0);
    chk("rst_release", int'(key_release), 0);
    chk("rst_repeat", int'(key_repeat), 0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_state", int'(key_state), 0);

    for (int i = 0; i < 16; i++) begin
      exp_t e;
      key_in = vt[i].k;
      e.due  = cyc + vt[i].w;
      e.id   = i;
      e.st   = vt[i].st;
      e.pr   = vt[i].pr;
      e.rl   = vt[i].rl;
      sb.push_back(e);
      repeat (vt[i].w) tick();
    end
    chk("scoreboard_drained", sb.size(), 0);

    // Bounce on channel 1: 6 low, 2 high, then low and held.
    clr_counts();
    key_in = 4'b1101;
    repeat (6) tick();
    key_in = 4'b1111;
    repeat (2) tick();
    key_in = 4'b1101;
    start  = cyc;
    repeat (20) tick();
    chk("bounce_press_count", press_cnt[1], 1);
    chk("bounce_press_edge", first_press[1] - start, 12);
    chk("bounce_no_release", rel_cnt[1], 0);
    chk("bounce_state", int'(key_state), 4'b0010);
    key_in = 4'b1111;
    repeat (13) tick();
    chk("bounce_release_count", rel_cnt[1], 1);
    chk("bounce_released_state", int'(key_state), 0);

    // Reset with channel 3 mid-debounce and still held through reset release.
    clr_counts();
    key_in = 4'b0111;
    repeat (7) tick();
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_state", int'(key_state), 0);
    chk("midrst_press", int'(key_press), 0);
    chk("midrst_release", int'(key_release), 0);
    repeat (2) tick();
    sys_rst_n = 1'b1;
    start     = cyc;
    repeat (11) tick();
    chk("postrst_edge11_state", int'(key_state), 0);
    chk("postrst_edge11_press_count", press_cnt[3], 0);
    tick();
    chk("postrst_edge12_state", int'(key_state), 4'b1000);
    chk("postrst_edge12_press", int'(key_press), 4'b1000);
    chk("postrst_press_edge", first_press[3] - start, 12);
    key_in = 4'b1111;
    repeat (13) tick();
    chk("postrst_released", int'(key_state), 0);

`ifdef KEY_FILTER_REPEAT_EN
    key_in = 4'b1011;
    repeat (12) tick();
    chk("rep_pressed", int'(key_state), 4'b0100);
    edge_k  = cyc;
    rep_cnt = 0;
    rep_at.delete();
    repeat (31) tick();
    chk("rep_count", rep_cnt, 3);
    if (rep_at.size() >= 3) begin
      chk("rep_first", rep_at[0] - edge_k, 20);
      chk("rep_second", rep_at[1] - edge_k, 25);
      chk("rep_third", rep_at[2] - edge_k, 30);
    end
    key_in = 4'b1111;
    repeat (12) tick();
    chk("rep_released", int'(key_state), 0);
    rep_cnt = 0;
    repeat (15) tick();
    chk("rep_stopped", rep_cnt, 0);
`else
    edge_k = cyc;
    key_in = 4'b1011;
    repeat (40) tick();
    chk("norep_held_state", int'(key_state), 4'b0100);
    chk("norep_elapsed", cyc - edge_k, 40);
    key_in = 4'b1111;
    repeat (13) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
